mem_access_unit: RTL and testbench

Load/store initiator between the MIPS datapath and the word-organised data memory. Accepts one byte, halfword or word access at a time over a valid/ready request port and drives the memory's write-enable, read-enable, word address and write data. Sub-word stores use a read-modify-write sequence; sub-word loads are extracted and extended. Every accepted request returns exactly one single-cycle response, optionally flagged as an error.

---
 rtl/mem_access_pkg.sv | 29 ++
 rtl/mem_access_if.sv | 36 +++
 rtl/mem_lane_align.sv | 65 ++++++
 rtl/mem_access_unit.sv | 150 +++++++++++++++
 tb/tb_mem_access_unit.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store initiator: access size encodings,
// controller state encoding, byte-lane widths and a word-index helper.
package mem_access_pkg;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;
  localparam int LANES  = WORD_W / BYTE_W;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_e;

  // Byte address to memory word index ({2'b00, addr[31:2]}).
  function automatic logic [WORD_W-1:0] wordIndex(input logic [WORD_W-1:0] byteAddr);
    return WORD_W'(byteAddr >> 2);
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Request/response handshake plus data-memory bus of the load/store unit.
// The unit itself uses the slave view; the datapath/memory side uses master.
interface mem_access_if;
  import mem_access_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;

  logic              resp_valid;
  logic              resp_err;
  logic [WORD_W-1:0] resp_rdata;

  logic              mem_write;
  logic              mem_read;
  logic [WORD_W-1:0] mem_address;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
           mem_write, mem_read, mem_address, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           mem_write, mem_read, mem_address, mem_wdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: extracts and extends sub-word load data
// and merges sub-word store data into a previously read word.
// Lanes are little-endian: lane k occupies bits [8k+7:8k].
module mem_lane_align
  import mem_access_pkg::*;
(
  input  size_e             size,
  input  logic              signExt,
  input  logic [1:0]        byteOff,
  input  logic [WORD_W-1:0] rdata,
  input  logic [WORD_W-1:0] mergeWord,
  input  logic [WORD_W-1:0] storeData,
  output logic [WORD_W-1:0] loadData,
  output logic [WORD_W-1:0] mergedData
);

  logic [BYTE_W-1:0] rdLane [LANES];
  logic [BYTE_W-1:0] byteSel;
  logic [HALF_W-1:0] halfSel;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [1:0] LANE_ID = 2'(gi);
      logic [BYTE_W-1:0] storeByte;
      logic              hit;

      assign rdLane[gi] = rdata[gi*BYTE_W +: BYTE_W];

      // Decide whether this lane is overwritten and which store byte feeds it
      always_comb begin
        storeByte = storeData[gi*BYTE_W +: BYTE_W];
        hit       = 1'b0;
        case (size)
          SIZE_BYTE: begin
            storeByte = storeData[BYTE_W-1:0];
            hit       = (byteOff == LANE_ID);
          end
          SIZE_HALF: begin
            storeByte = storeData[(gi % 2)*BYTE_W +: BYTE_W];
            hit       = (byteOff[1] == LANE_ID[1]);
          end
          SIZE_WORD: hit = 1'b1;
          default:   hit = 1'b0;
        endcase
      end

      assign mergedData[gi*BYTE_W +: BYTE_W] = hit ? storeByte : mergeWord[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

  assign byteSel = rdLane[byteOff];
  assign halfSel = byteOff[1] ? rdata[WORD_W-1:HALF_W] : rdata[HALF_W-1:0];

  // Right-justify the selected lane(s) and zero/sign-extend
  always_comb begin
    loadData = rdata;
    case (size)
      SIZE_BYTE: loadData = {{(WORD_W-BYTE_W){signExt & byteSel[BYTE_W-1]}}, byteSel};
      SIZE_HALF: loadData = {{(WORD_W-HALF_W){signExt & halfSel[HALF_W-1]}}, halfSel};
      default:   loadData = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the datapath and a word-organised data memory.
// One access at a time: loads read once, word stores write once, sub-word
// stores read-modify-write. Each accepted request gets one response pulse.
// Optional feature macro: ALIGN_CHECK_EN -- when defined, misaligned halfword
// and word accesses are rejected; otherwise the low address bits are cleared.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int MEMORY_DEPTH = 32
)(
  input logic        clk,
  input logic        reset,
  mem_access_if.slave bus
);

  localparam logic [DATA_WIDTH-3:0] DEPTH_LIMIT = (DATA_WIDTH-2)'(MEMORY_DEPTH);

  state_e                stateReg, stateNext;
  logic                  writeReg, signedReg, respErrReg;
  size_e                 sizeReg, reqSize;
  logic [DATA_WIDTH-1:0] addrReg, wdataReg, mergeReg, respRdataReg;
  logic [DATA_WIDTH-1:0] effAddr, loadData, mergedData;
  logic                  accept, reqErr, sizeErr, rangeErr;

  assign reqSize  = size_e'(bus.req_size);
  assign accept   = bus.req_valid && (stateReg == IDLE);
  assign sizeErr  = (reqSize == SIZE_RSVD);
  assign rangeErr = (bus.req_addr[DATA_WIDTH-1:2] >= DEPTH_LIMIT);

`ifdef ALIGN_CHECK_EN
  logic misalign;
  assign misalign = ((reqSize == SIZE_HALF) && bus.req_addr[0]) ||
                    ((reqSize == SIZE_WORD) && (bus.req_addr[1:0] != 2'b00));
  assign reqErr   = sizeErr || rangeErr || misalign;
  assign effAddr  = bus.req_addr;
`else
  assign reqErr = sizeErr || rangeErr;

  // Clear the sub-alignment bits so the access lands on a natural boundary
  always_comb begin
    effAddr = bus.req_addr;
    if (reqSize == SIZE_HALF)      effAddr[0]   = 1'b0;
    else if (reqSize == SIZE_WORD) effAddr[1:0] = 2'b00;
  end
`endif

  mem_lane_align u_align (
    .size       (sizeReg),
    .signExt    (signedReg),
    .byteOff    (addrReg[1:0]),
    .rdata      (bus.mem_rdata),
    .mergeWord  (mergeReg),
    .storeData  (wdataReg),
    .loadData   (loadData),
    .mergedData (mergedData)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) stateReg <= IDLE;
    else       stateReg <= stateNext;
  end

  // Next state: errors skip the memory phase; sub-word stores read first
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: begin
        if (accept) begin
          if (reqErr)                                    stateNext = RESP;
          else if (bus.req_write && reqSize == SIZE_WORD) stateNext = WR;
          else                                           stateNext = RD;
        end
      end
      RD:      stateNext = writeReg ? WR : RESP;
      WR:      stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Memory and handshake strobes decoded purely from state and latched fields
  always_comb begin
    bus.req_ready   = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_address = '0;
    bus.mem_wdata   = '0;
    case (stateReg)
      IDLE: bus.req_ready = 1'b1;
      RD: begin
        bus.mem_read    = 1'b1;
        bus.mem_address = wordIndex(addrReg);
      end
      WR: begin
        bus.mem_write   = 1'b1;
        bus.mem_address = wordIndex(addrReg);
        bus.mem_wdata   = mergedData;
      end
      RESP:    bus.resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.resp_err   = respErrReg;
  assign bus.resp_rdata = respRdataReg;

  // Capture the request fields at the accept edge
  always_ff @(posedge clk) begin
    if (reset) begin
      writeReg  <= 1'b0;
      sizeReg   <= SIZE_BYTE;
      signedReg <= 1'b0;
      addrReg   <= '0;
      wdataReg  <= '0;
    end else if (accept) begin
      writeReg  <= bus.req_write;
      sizeReg   <= reqSize;
      signedReg <= bus.req_signed;
      addrReg   <= effAddr;
      wdataReg  <= bus.req_wdata;
    end
  end

  // Hold the old memory word for the read-modify-write merge
  always_ff @(posedge clk) begin
    if (reset)                        mergeReg <= '0;
    else if (stateReg == RD && writeReg) mergeReg <= bus.mem_rdata;
  end

  // Response fields change only on the edge that enters RESP, then hold
  always_ff @(posedge clk) begin
    if (reset) begin
      respErrReg   <= 1'b0;
      respRdataReg <= '0;
    end else if (accept && reqErr) begin
      respErrReg   <= 1'b1;
      respRdataReg <= '0;
    end else if (stateReg == RD && !writeReg) begin
      respErrReg   <= 1'b0;
      respRdataReg <= loadData;
    end else if (stateReg == WR) begin
      respErrReg   <= 1'b0;
      respRdataReg <= '0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 32-word behavioural memory.
// Expected values are hand-computed; the ALIGN_CHECK_EN build selects the
// expectations for the misaligned halfword load.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic clk;
  logic reset;
  logic preload;
  mem_access_if bus();

  logic [31:0] mem [32];
  int nChecks = 0;
  int nFails  = 0;

  int          respCycle, readCnt, writeCnt, readCycle, writeCycle;
  logic        rErr, readyC1;
  logic [31:0] rData, wAddr, wData;

  mem_access_unit #(.DATA_WIDTH(32), .MEMORY_DEPTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_address[4:0]];

  // Memory model: preload image, otherwise commit writes at the clock edge
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      mem[0]  <= 32'h1122C3D4;
      mem[3]  <= 32'h8899AABB;
      mem[31] <= 32'hCAFEF00D;
    end else if (bus.mem_write) begin
      mem[bus.mem_address[4:0]] <= bus.mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic doReq(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    respCycle = 0; readCnt = 0; writeCnt = 0; readCycle = 0; writeCycle = 0;
    rErr = 1'bx; rData = 'x; wAddr = 'x; wData = 'x; readyC1 = 1'bx;
    for (int c = 1; c <= 6; c++) begin
      if (respCycle != 0) break;
      @(negedge clk);
      if (c == 1) readyC1 = bus.req_ready;
      if (bus.mem_read) begin
        readCnt++;
        if (readCycle == 0) readCycle = c;
      end
      if (bus.mem_write) begin
        writeCnt++;
        writeCycle = c;
        wAddr = bus.mem_address;
        wData = bus.mem_wdata;
      end
      if (bus.resp_valid) begin
        respCycle = c;
        rErr  = bus.resp_err;
        rData = bus.resp_rdata;
      end
    end
    $display("txn w=%0b size=%0d signed=%0b addr=0x%08h wdata=0x%08h -> resp@%0d err=%0b rdata=0x%08h reads=%0d writes=%0d",
             w, sz, sg, a, d, respCycle, rErr, rData, readCnt, writeCnt);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    reset   = 1'b1;
    preload = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready",   32'(bus.req_ready),  32'h1);
    check("rst_resp_valid",  32'(bus.resp_valid), 32'h0);
    check("rst_resp_err",    32'(bus.resp_err),   32'h0);
    check("rst_resp_rdata",  bus.resp_rdata,      32'h0);
    check("rst_mem_write",   32'(bus.mem_write),  32'h0);
    check("rst_mem_read",    32'(bus.mem_read),   32'h0);
    check("rst_mem_address", bus.mem_address,     32'h0);
    check("rst_mem_wdata",   bus.mem_wdata,       32'h0);
    reset   = 1'b0;
    preload = 1'b0;

    // Signed byte load from lane 1 of word 3
    doReq(1'b0, 2'b00, 1'b1, 32'h0000000D, 32'h0);
    check("lb_s_cycle",  32'(respCycle), 32'd2);
    check("lb_s_rdata",  rData,          32'hFFFFFFAA);
    check("lb_s_err",    32'(rErr),      32'h0);
    check("lb_s_reads",  32'(readCnt),   32'd1);
    check("lb_s_ready1", 32'(readyC1),   32'h0);

    // Same access, zero-extended
    doReq(1'b0, 2'b00, 1'b0, 32'h0000000D, 32'h0);
    check("lb_u_rdata", rData,          32'h000000AA);
    check("lb_u_cycle", 32'(respCycle), 32'd2);

    // Signed halfword load from upper half of word 3
    doReq(1'b0, 2'b01, 1'b1, 32'h0000000E, 32'h0);
    check("lh_s_rdata", rData, 32'hFFFF8899);

    // Byte store: read-modify-write into lane 2
    doReq(1'b1, 2'b00, 1'b0, 32'h0000000E, 32'h00000011);
    check("sb_read_cyc",  32'(readCycle),  32'd1);
    check("sb_write_cyc", 32'(writeCycle), 32'd2);
    check("sb_writes",    32'(writeCnt),   32'd1);
    check("sb_waddr",     wAddr,           32'd3);
    check("sb_wdata",     wData,           32'h8811AABB);
    check("sb_cycle",     32'(respCycle),  32'd3);
    check("sb_rdata",     rData,           32'h0);

    // Word load sees the merged result
    doReq(1'b0, 2'b10, 1'b0, 32'h0000000C, 32'h0);
    check("lw_rdata", rData,          32'h8811AABB);
    check("lw_cycle", 32'(respCycle), 32'd2);

    // Word store: single write, no read
    doReq(1'b1, 2'b10, 1'b0, 32'h00000010, 32'hDEADBEEF);
    check("sw_writes", 32'(writeCnt),  32'd1);
    check("sw_reads",  32'(readCnt),   32'd0);
    check("sw_waddr",  wAddr,          32'd4);
    check("sw_wdata",  wData,          32'hDEADBEEF);
    check("sw_cycle",  32'(respCycle), 32'd2);
    check("sw_err",    32'(rErr),      32'h0);
    @(negedge clk);
    check("sw_mem4",   mem[4],         32'hDEADBEEF);

    // Halfword store into upper half of word 4
    doReq(1'b1, 2'b01, 1'b0, 32'h00000012, 32'h00005566);
    check("sh_wdata", wData,          32'h5566BEEF);
    check("sh_cycle", 32'(respCycle), 32'd3);

    // Misaligned halfword load
    doReq(1'b0, 2'b01, 1'b1, 32'h00000001, 32'h0);
`ifdef ALIGN_CHECK_EN
    check("lh_mis_err",   32'(rErr),      32'h1);
    check("lh_mis_cycle", 32'(respCycle), 32'd1);
    check("lh_mis_reads", 32'(readCnt),   32'd0);
    check("lh_mis_rdata", rData,          32'h0);
`else
    check("lh_mis_err",   32'(rErr),      32'h0);
    check("lh_mis_cycle", 32'(respCycle), 32'd2);
    check("lh_mis_rdata", rData,          32'hFFFFC3D4);
`endif

    // Word index 32 is out of range
    doReq(1'b0, 2'b10, 1'b0, 32'h00000080, 32'h0);
    check("range_err",   32'(rErr),      32'h1);
    check("range_rdata", rData,          32'h0);
    check("range_cycle", 32'(respCycle), 32'd1);
    check("range_reads", 32'(readCnt),   32'd0);
    @(negedge clk);
    check("err_hold",    32'(bus.resp_err),   32'h1);
    check("err_novalid", 32'(bus.resp_valid), 32'h0);

    // Last valid word index
    doReq(1'b0, 2'b10, 1'b0, 32'h0000007C, 32'h0);
    check("last_rdata", rData,     32'hCAFEF00D);
    check("last_err",   32'(rErr), 32'h0);

    // Reserved size
    doReq(1'b0, 2'b11, 1'b0, 32'h00000000, 32'h0);
    check("rsvd_err",   32'(rErr),      32'h1);
    check("rsvd_cycle", 32'(respCycle), 32'd1);

    // Reset during the read phase of a byte store aborts it
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0000000C;
    bus.req_wdata  = 32'h00000077;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("abort_in_rd", 32'(bus.mem_read), 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    writeCnt  = 0;
    respCycle = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.mem_write)  writeCnt++;
      if (bus.resp_valid) respCycle++;
    end
    $display("txn reset-in-RD byte store addr=0x0000000C -> writes=%0d resps=%0d ready=%0b mem3=0x%08h",
             writeCnt, respCycle, bus.req_ready, mem[3]);
    check("abort_writes", 32'(writeCnt),      32'd0);
    check("abort_resps",  32'(respCycle),     32'd0);
    check("abort_ready",  32'(bus.req_ready), 32'h1);
    check("abort_mem3",   mem[3],             32'h8811AABB);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
